// File: rtl/pad_poll_scheduler.sv
// Polls two NES-style pads over a shared latch/clock pair and holds the decoded
// frame for a valid/ready consumer. Define PAD_EDGE_EN to add press-edge masks.
module pad_poll_scheduler #(
  parameter int unsigned HALF        = 256,
  parameter int unsigned POLL_PERIOD = 262144
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       poll_req,
  input  logic       data_p1,
  input  logic       data_p2,
  output logic       latch,
  output logic       clock,
  output logic       busy,
  output logic [7:0] buttons_p1,
  output logic [7:0] buttons_p2,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       overrun
`ifdef PAD_EDGE_EN
  ,
  output logic [7:0] pressed_p1,
  output logic [7:0] pressed_p2
`endif
);

  localparam int unsigned CW = $clog2(2 * HALF);
  localparam int unsigned PW = $clog2(POLL_PERIOD);
  localparam logic [CW-1:0] LATCH_LAST = CW'(2 * HALF - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF - 1);
  localparam logic [PW-1:0] PER_LAST   = PW'(POLL_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, LATCH, HIGH, LOW, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [PW-1:0] per_q, per_d;
  logic [7:0]    sr1_q, sr1_d, sr2_q, sr2_d;
  logic [7:0]    btn1_q, btn1_d, btn2_q, btn2_d;
  logic          latch_q, latch_d, clock_q, clock_d, busy_q, busy_d;
  logic          valid_q, valid_d, ovr_q, ovr_d;
`ifdef PAD_EDGE_EN
  logic [7:0]    prs1_q, prs1_d, prs2_q, prs2_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sr1_d   = sr1_q;
    sr2_d   = sr2_q;
    btn1_d  = btn1_q;
    btn2_d  = btn2_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
`ifdef PAD_EDGE_EN
    prs1_d  = prs1_q;
    prs2_d  = prs2_q;
`endif
    per_d = (per_q == PER_LAST) ? '0 : per_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        // Auto-start and poll_req merge into one start decision.
        if ((per_q == PER_LAST) || poll_req) begin
          state_d = LATCH;
          cnt_d   = '0;
        end
      end
      LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          sr1_d[0] = data_p1;
          sr2_d[0] = data_p2;
          bit_d    = 3'd1;
          cnt_d    = '0;
          state_d  = HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HIGH: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = LOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOW: begin
        if (cnt_q == HALF_LAST) begin
          sr1_d[bit_q] = data_p1;
          sr2_d[bit_q] = data_p2;
          cnt_d        = '0;
          if (bit_q == 3'd7) begin
            state_d = DONE;
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        btn1_d  = ~sr1_q;
        btn2_d  = ~sr2_q;
        valid_d = 1'b1;
        ovr_d   = valid_q && !frame_ready;
`ifdef PAD_EDGE_EN
        prs1_d  = ~sr1_q & ~btn1_q;
        prs2_d  = ~sr2_q & ~btn2_q;
`endif
      end
      default: state_d = IDLE;
    endcase

    // A DONE load wins over a same-cycle acceptance.
    if (state_q != DONE && valid_q && frame_ready) begin
      valid_d = 1'b0;
`ifdef PAD_EDGE_EN
      prs1_d  = '0;
      prs2_d  = '0;
`endif
    end

    latch_d = (state_d == LATCH);
    clock_d = (state_d == HIGH);
    busy_d  = (state_d == LATCH) || (state_d == HIGH) || (state_d == LOW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      per_q   <= '0;
      sr1_q   <= '0;
      sr2_q   <= '0;
      btn1_q  <= '0;
      btn2_q  <= '0;
      latch_q <= 1'b0;
      clock_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef PAD_EDGE_EN
      prs1_q  <= '0;
      prs2_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      per_q   <= per_d;
      sr1_q   <= sr1_d;
      sr2_q   <= sr2_d;
      btn1_q  <= btn1_d;
      btn2_q  <= btn2_d;
      latch_q <= latch_d;
      clock_q <= clock_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef PAD_EDGE_EN
      prs1_q  <= prs1_d;
      prs2_q  <= prs2_d;
`endif
    end
  end

  assign latch       = latch_q;
  assign clock       = clock_q;
  assign busy        = busy_q;
  assign buttons_p1  = btn1_q;
  assign buttons_p2  = btn2_q;
  assign frame_valid = valid_q;
  assign overrun     = ovr_q;
`ifdef PAD_EDGE_EN
  assign pressed_p1  = prs1_q;
  assign pressed_p2  = prs2_q;
`endif

endmodule

// File: tb/tb_pad_poll_scheduler.sv
// Scoreboard bench for pad_poll_scheduler (HALF=4, POLL_PERIOD=200) with a
// behavioural pad model; frames are queued at poll start and checked at load.
module tb_pad_poll_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       poll_req = 1'b0;
  logic       frame_ready = 1'b1;
  logic       data_p1, data_p2;
  logic       latch, clock, busy, frame_valid, overrun;
  logic [7:0] buttons_p1, buttons_p2;
`ifdef PAD_EDGE_EN
  logic [7:0] pressed_p1, pressed_p2;
`endif

  pad_poll_scheduler #(.HALF(4), .POLL_PERIOD(200)) dut (
    .clk(clk), .rst_n(rst_n), .poll_req(poll_req),
    .data_p1(data_p1), .data_p2(data_p2),
    .latch(latch), .clock(clock), .busy(busy),
    .buttons_p1(buttons_p1), .buttons_p2(buttons_p2),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .overrun(overrun)
`ifdef PAD_EDGE_EN
    , .pressed_p1(pressed_p1), .pressed_p2(pressed_p2)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pad model: active-high pattern, shifted out active-low, bit advances on clock rise.
  logic [7:0] pat1 = 8'h00;
  logic [7:0] pat2 = 8'h00;
  int pidx = 0;
  always @(posedge latch or posedge clock) begin
    if (latch) pidx <= 0;
    else       pidx <= pidx + 1;
  end
  assign data_p1 = (pidx < 8) ? ~pat1[pidx[2:0]] : 1'b1;
  assign data_p2 = (pidx < 8) ? ~pat2[pidx[2:0]] : 1'b1;

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  logic [15:0] exp_q[$];
  int polls = 0;

  // Issuer: each poll start queues the frame the pads are presenting.
  initial begin
    logic prev_latch;
    prev_latch = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_latch = 1'b0;
      end else begin
        if (latch && !prev_latch) begin
          exp_q.push_back({pat1, pat2});
          polls++;
        end
        prev_latch = latch;
      end
    end
  end

  int ovr_seen = 0;

  // Monitor: waveform shape per poll, frame contents, valid/overrun model.
  initial begin
    logic [15:0] e;
    logic prev_busy, prev_clk, load_pend, mv, rdy_prev;
    int busy_cnt, lat_cnt, pulses, hi_run, lo_run, bad_hi;
    prev_busy = 0; prev_clk = 0; load_pend = 0; mv = 0; rdy_prev = 0;
    busy_cnt = 0; lat_cnt = 0; pulses = 0; hi_run = 0; lo_run = 0; bad_hi = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        prev_busy = 0; prev_clk = 0; load_pend = 0; mv = 0; rdy_prev = 0;
        busy_cnt = 0; lat_cnt = 0; pulses = 0; hi_run = 0; lo_run = 0; bad_hi = 0;
      end else begin
        if (overrun) ovr_seen++;
        if (load_pend) begin
          load_pend = 0;
          if (exp_q.size() == 0) begin
            chk("scoreboard_underflow", 0, 1);
          end else begin
            e = exp_q.pop_front();
            chk("buttons_p1", buttons_p1, e[15:8]);
            chk("buttons_p2", buttons_p2, e[7:0]);
          end
          chk("frame_valid_load", frame_valid, 1);
          chk("overrun_load", overrun, mv && !rdy_prev);
          mv = 1;
        end else begin
          if (mv && rdy_prev) mv = 0;
          chk("frame_valid", frame_valid, mv);
          chk("overrun_quiet", overrun, 0);
        end
        rdy_prev = frame_ready;

        if (busy) begin
          busy_cnt++;
          if (latch) lat_cnt++;
          if (clock) begin
            hi_run++;
            lo_run = 0;
            if (!prev_clk) pulses++;
          end else begin
            if (prev_clk) begin
              if (hi_run != 4) bad_hi++;
              hi_run = 0;
            end
            if (!latch) lo_run++;
          end
        end
        if (prev_busy && !busy) begin
          chk("busy_len", busy_cnt, 64);
          chk("latch_len", lat_cnt, 8);
          chk("clock_pulses", pulses, 7);
          chk("clock_high_bad_runs", bad_hi, 0);
          chk("final_low_len", lo_run, 4);
          busy_cnt = 0; lat_cnt = 0; pulses = 0; hi_run = 0; lo_run = 0; bad_hi = 0;
          load_pend = 1;
        end
        prev_busy = busy;
        prev_clk  = clock;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input int p);
    int n;
    n = 0;
    while ((cyc % 200) != p && n < 400) begin
      tick();
      n++;
    end
    chk("wait_phase", cyc % 200, p);
  endtask

  task automatic do_poll(input logic [7:0] a, input logic [7:0] b);
    pat1 = a;
    pat2 = b;
    poll_req = 1'b1;
    tick();
    poll_req = 1'b0;
    repeat (65) tick();
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0, o0, n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_latch", latch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", frame_valid, 0);
    chk("rst_buttons", {buttons_p1, buttons_p2}, 0);
    rst_n = 1'b1;

    // Idle pads, then a two-pad pattern.
    wait_phase(66);
    do_poll(8'h00, 8'h00);
    chk("idle_buttons", {buttons_p1, buttons_p2}, 16'h0000);
    chk("idle_valid", frame_valid, 1);
    do_poll(8'h11, 8'h80);
    chk("pattern_p1", buttons_p1, 8'h11);
    chk("pattern_p2", buttons_p2, 8'h80);

    // Two frames without acceptance.
    wait_phase(66);
    frame_ready = 1'b0;
    o0 = ovr_seen;
    do_poll(8'h3C, 8'h00);
    do_poll(8'hC3, 8'h81);
    chk("overrun_now", overrun, 1);
    chk("overwrite_p1", buttons_p1, 8'hC3);
    chk("overwrite_p2", buttons_p2, 8'h81);
    frame_ready = 1'b1;
    tick();
    chk("overrun_pulses", ovr_seen - o0, 1);
    pat1 = 8'h00;
    pat2 = 8'h00;

`ifdef PAD_EDGE_EN
    wait_phase(66);
    frame_ready = 1'b0;
    do_poll(8'h01, 8'h00);
    chk("pressed_first", pressed_p1, 8'h01);
    do_poll(8'h03, 8'h00);
    chk("pressed_second", pressed_p1, 8'h02);
    chk("pressed_p2_none", pressed_p2, 8'h00);
    frame_ready = 1'b1;
    tick();
    chk("pressed_cleared", pressed_p1, 8'h00);
`endif

    // poll_req while busy is dropped.
    wait_phase(66);
    p0 = polls;
    pat1 = 8'h24;
    pat2 = 8'h42;
    poll_req = 1'b1;
    tick();
    poll_req = 1'b0;
    repeat (19) tick();
    poll_req = 1'b1;
    tick();
    poll_req = 1'b0;
    repeat (45) tick();
    chk("busy_req_polls", polls - p0, 1);
    chk("busy_req_buttons", buttons_p1, 8'h24);
    tick();
    chk("busy_req_idle", busy, 0);

    // poll_req coinciding with the auto-start.
    wait_phase(199);
    p0 = polls;
    pat1 = 8'h5A;
    pat2 = 8'hA5;
    poll_req = 1'b1;
    tick();
    poll_req = 1'b0;
    repeat (65) tick();
    chk("coincide_buttons", buttons_p1, 8'h5A);
    tick();
    chk("coincide_polls", polls - p0, 1);
    chk("coincide_idle", busy, 0);

    // Reset in the middle of a poll.
    poll_req = 1'b1;
    tick();
    poll_req = 1'b0;
    repeat (29) tick();
    chk("midpoll_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_latch", latch, 0);
    chk("async_clock", clock, 0);
    chk("async_busy", busy, 0);
    chk("async_valid", frame_valid, 0);
    chk("async_buttons", {buttons_p1, buttons_p2}, 0);
`ifdef PAD_EDGE_EN
    chk("async_pressed", {pressed_p1, pressed_p2}, 0);
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    while (!latch && n < 400) begin
      tick();
      n++;
    end
    chk("first_auto_after_reset", n, 200);
    chk("no_frame_after_reset", frame_valid, 0);
    repeat (70) tick();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
